// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the debouncer slice (synchronizer, arm stage
// debounce_part_1, timing/output stage debounce_part_2).
//   db_state_t              : timing-stage FSM state (IDLE/COUNT/DONE, 2 bits)
//   DEFAULT_DEBOUNCE_CYCLES : quiet-window length in clocks (10 ms at 50 MHz)
//   DEFAULT_CNT_WIDTH       : counter width able to hold DEFAULT_DEBOUNCE_CYCLES-1
// -----------------------------------------------------------------------------
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } db_state_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
   localparam int DEFAULT_CNT_WIDTH       = 19;

endpackage

// File: rtl/debounce_timer.sv
// -----------------------------------------------------------------------------
// debounce_timer
// Quiet-window counter for the debouncer timing stage.
// Ports:
//   clk      in   system clock, posedge
//   rst_n    in   asynchronous active-low reset
//   clear    in   force the count to 0 (wins over enable)
//   enable   in   advance the count by one
//   cnt      out  current count, CNT_WIDTH bits, unsigned
//   terminal out  cnt == DEBOUNCE_CYCLES-1 (truncated to CNT_WIDTH)
// -----------------------------------------------------------------------------
module debounce_timer
   import debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 enable,
   output logic [CNT_WIDTH-1:0] cnt,
   output logic                 terminal
);

   localparam logic [CNT_WIDTH-1:0] TERM_CNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [CNT_WIDTH-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (clear) begin
         cnt_reg <= '0;
      end else if (enable) begin
         cnt_reg <= cnt_reg + CNT_WIDTH'(1);
      end
   end

   assign cnt      = cnt_reg;
   assign terminal = (cnt_reg == TERM_CNT);

endmodule

// File: rtl/debounce_part_2.sv
// -----------------------------------------------------------------------------
// debounce_part_2
// Timing and output stage of the debouncer. While the arm stage holds "state"
// high, a quiet window of DEBOUNCE_CYCLES clocks is timed; any sig_change
// restarts it. At window end a one-cycle count_finished is returned to the arm
// stage and, in the same cycle, the synchronized level is committed to db_out
// with a matching rise/fall pulse when the level actually changed.
// Ports:
//   clk            in   system clock, posedge
//   rst_n          in   asynchronous active-low reset
//   state          in   arm level from debounce_part_1 (high = window wanted)
//   sig_change     in   synchronizer change strobe, restarts the window
//   sig_sync       in   synchronized raw input level
//   count_finished out  one-cycle window-done pulse (registered)
//   db_out         out  debounced level (registered)
//   rise_pulse     out  one-cycle pulse on db_out 0->1 (registered)
//   fall_pulse     out  one-cycle pulse on db_out 1->0 (registered)
// -----------------------------------------------------------------------------
module debounce_part_2
   import debounce_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int   CNT_WIDTH       = DEFAULT_CNT_WIDTH,
   parameter logic INIT_LEVEL      = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic state,
   input  logic sig_change,
   input  logic sig_sync,
   output logic count_finished,
   output logic db_out,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam logic [CNT_WIDTH-1:0] TERM_CNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   db_state_t            state_reg, state_next;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 terminal;
   logic                 timer_clear;
   logic                 timer_enable;

   logic count_finished_reg, count_finished_next;
   logic db_out_reg,         db_out_next;
   logic rise_reg,           rise_next;
   logic fall_reg,           fall_next;

   debounce_timer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (timer_clear),
      .enable   (timer_enable),
      .cnt      (cnt),
      .terminal (terminal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg          <= IDLE;
         count_finished_reg <= 1'b0;
         db_out_reg         <= INIT_LEVEL;
         rise_reg           <= 1'b0;
         fall_reg           <= 1'b0;
      end else begin
         state_reg          <= state_next;
         count_finished_reg <= count_finished_next;
         db_out_reg         <= db_out_next;
         rise_reg           <= rise_next;
         fall_reg           <= fall_next;
      end
   end

   // Outputs are computed as next-values here and registered above, so every
   // output is a flop and there is no input-to-output combinational path.
   // The counter is cleared on every edge except a plain "keep counting" edge.
   always_comb begin
      state_next          = state_reg;
      timer_clear         = 1'b1;
      timer_enable        = 1'b0;
      count_finished_next = 1'b0;
      db_out_next         = db_out_reg;
      rise_next           = 1'b0;
      fall_next           = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (state) begin
               state_next = COUNT;
            end
         end
         COUNT: begin
            if (!state) begin
               // Arm stage withdrew the request: drop the window, keep db_out.
               state_next = IDLE;
            end else if (sig_change) begin
               // Bounce seen: restart the window; wins over terminal count.
               state_next = COUNT;
            end else if (terminal) begin
               state_next          = DONE;
               count_finished_next = 1'b1;
               db_out_next         = sig_sync;
               rise_next           = sig_sync & ~db_out_reg;
               fall_next           = ~sig_sync & db_out_reg;
            end else begin
               timer_clear  = 1'b0;
               // Saturation guard: the count can never step past the window end.
               timer_enable = (cnt != TERM_CNT);
            end
         end
         DONE: begin
            // One cycle only; the arm stage clears state on the edge leaving DONE.
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign count_finished = count_finished_reg;
   assign db_out         = db_out_reg;
   assign rise_pulse     = rise_reg;
   assign fall_pulse     = fall_reg;

endmodule

// File: tb/tb_debounce_part_2.sv
// -----------------------------------------------------------------------------
// tb_debounce_part_2
// Directed bench for debounce_part_2 with DEBOUNCE_CYCLES=8, CNT_WIDTH=3,
// INIT_LEVEL=0. A window model based on edge numbers (edge of window start vs.
// current edge) predicts the outputs; every cycle the DUT is compared with it,
// and hand-computed literals pin latencies, levels and pulse counts.
// -----------------------------------------------------------------------------
module tb_debounce_part_2;

   localparam int   DC   = 8;
   localparam int   CW   = 3;
   localparam logic INIT = 1'b0;

   logic clk = 1'b0;
   logic rst_n;
   logic state;
   logic sig_change;
   logic sig_sync;
   logic count_finished;
   logic db_out;
   logic rise_pulse;
   logic fall_pulse;

   always #5 clk = ~clk;

   debounce_part_2 #(
      .DEBOUNCE_CYCLES (DC),
      .CNT_WIDTH       (CW),
      .INIT_LEVEL      (INIT)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .state          (state),
      .sig_change     (sig_change),
      .sig_sync       (sig_sync),
      .count_finished (count_finished),
      .db_out         (db_out),
      .rise_pulse     (rise_pulse),
      .fall_pulse     (fall_pulse)
   );

   // ---------------- behavioural model ----------------
   // A window opens on the edge where state is seen high; a change strobe moves
   // the window start to that edge; the window finishes on the edge DC edges
   // after its start. The cycle after a finish ignores the arm level.
   int   cyc = 0;
   int   m_start;
   logic m_win, m_cf, m_db, m_rise, m_fall;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_win   <= 1'b0;
         m_start <= 0;
         m_cf    <= 1'b0;
         m_db    <= INIT;
         m_rise  <= 1'b0;
         m_fall  <= 1'b0;
      end else begin
         m_cf   <= 1'b0;
         m_rise <= 1'b0;
         m_fall <= 1'b0;
         if (m_cf) begin
            m_win <= 1'b0;
         end else if (!m_win) begin
            if (state) begin
               m_win   <= 1'b1;
               m_start <= cyc;
            end
         end else if (!state) begin
            m_win <= 1'b0;
         end else if (sig_change) begin
            m_start <= cyc;
         end else if (cyc - m_start == DC) begin
            m_win  <= 1'b0;
            m_cf   <= 1'b1;
            m_db   <= sig_sync;
            m_rise <= sig_sync && !m_db;
            m_fall <= !sig_sync && m_db;
         end
      end
   end

   // ---------------- checking ----------------
   int   checks = 0;
   int   failures = 0;
   logic cmp_en = 1'b0;
   int   rise_seen = 0;
   int   fall_seen = 0;
   int   cf_seen = 0;
   int   n;

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance one clock; sample 1 time unit after the edge, compare with model.
   task automatic tick();
      @(posedge clk);
      #1;
      if (cmp_en) begin
         chk("model_count_finished", count_finished, m_cf);
         chk("model_db_out", db_out, m_db);
         chk("model_rise_pulse", rise_pulse, m_rise);
         chk("model_fall_pulse", fall_pulse, m_fall);
         chk("pulse_exclusive", rise_pulse & fall_pulse, 1'b0);
      end
      if (rise_pulse === 1'b1) rise_seen++;
      if (fall_pulse === 1'b1) fall_seen++;
      if (count_finished === 1'b1) cf_seen++;
   endtask

   // Clocks until count_finished is seen, bounded at 40.
   task automatic wait_cf(output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (count_finished !== 1'b1 && cycles < 40);
   endtask

   // Arm-stage handshake: state is cleared on the edge that ends DONE.
   task automatic finish_handshake();
      tick();
      state = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      rst_n = 1'b0; state = 1'b1; sig_change = 1'b1; sig_sync = 1'b1;

      // 1. reset
      tick();
      cmp_en = 1'b1;
      tick();
      tick();
      chk("reset_db_out", db_out, 1'b0);
      chk("reset_count_finished", count_finished, 1'b0);
      chk("reset_rise", rise_pulse, 1'b0);
      chk("reset_fall", fall_pulse, 1'b0);
      state = 1'b0; sig_change = 1'b0; sig_sync = 1'b0;
      rst_n = 1'b1;
      repeat (3) tick();
      chk("post_release_db_out", db_out, 1'b0);
      chk("post_release_cf", count_finished, 1'b0);
      $display("txn reset: db_out=%b cf=%b", db_out, count_finished);

      // 2. clean press
      sig_sync = 1'b1; state = 1'b1; rise_seen = 0;
      tick();
      wait_cf(n);
      chk_int("press_latency", n, DC);
      chk("press_db_out", db_out, 1'b1);
      chk("press_rise", rise_pulse, 1'b1);
      tick();
      chk("press_rise_after", rise_pulse, 1'b0);
      chk("press_cf_after", count_finished, 1'b0);
      state = 1'b0;
      tick(); tick();
      chk_int("press_rise_count", rise_seen, 1);
      $display("txn press: latency=%0d db_out=%b rises=%0d", n, db_out, rise_seen);

      // 5. release
      sig_sync = 1'b0; state = 1'b1; rise_seen = 0; fall_seen = 0;
      tick();
      wait_cf(n);
      chk_int("release_latency", n, DC);
      chk("release_db_out", db_out, 1'b0);
      chk("release_fall", fall_pulse, 1'b1);
      chk("release_rise", rise_pulse, 1'b0);
      tick();
      chk("release_fall_after", fall_pulse, 1'b0);
      state = 1'b0;
      tick(); tick();
      chk_int("release_fall_count", fall_seen, 1);
      $display("txn release: latency=%0d db_out=%b falls=%0d", n, db_out, fall_seen);

      // 3. bounce restart at cnt=5 and cnt=7
      sig_sync = 1'b1; state = 1'b1; rise_seen = 0; cf_seen = 0;
      tick();
      repeat (5) tick();
      sig_change = 1'b1;
      tick();
      sig_change = 1'b0;
      repeat (7) tick();
      sig_change = 1'b1;
      tick();
      sig_change = 1'b0;
      chk_int("bounce_no_early_finish", cf_seen, 0);
      wait_cf(n);
      chk_int("bounce_latency_after_last_change", n, DC);
      chk("bounce_db_out", db_out, 1'b1);
      finish_handshake();
      chk_int("bounce_rise_count", rise_seen, 1);
      $display("txn bounce: latency=%0d rises=%0d", n, rise_seen);

      // 4. glitch rejection
      sig_sync = 1'b1; state = 1'b1; fall_seen = 0; cf_seen = 0;
      tick();
      tick(); tick();
      sig_sync = 1'b0; sig_change = 1'b1;
      tick();
      sig_change = 1'b0;
      tick();
      sig_sync = 1'b1; sig_change = 1'b1;
      tick();
      sig_change = 1'b0;
      wait_cf(n);
      chk_int("glitch_latency", n, DC);
      chk("glitch_db_out", db_out, 1'b1);
      finish_handshake();
      chk_int("glitch_fall_count", fall_seen, 0);
      chk_int("glitch_cf_count", cf_seen, 1);
      $display("txn glitch: latency=%0d db_out=%b falls=%0d", n, db_out, fall_seen);

      // 6a. abort at cnt=4
      sig_sync = 1'b0; state = 1'b1; cf_seen = 0;
      tick();
      repeat (4) tick();
      state = 1'b0;
      repeat (12) tick();
      chk_int("abort_cf_count", cf_seen, 0);
      chk("abort_db_out", db_out, 1'b1);
      $display("txn abort: cf_seen=%0d db_out=%b", cf_seen, db_out);

      // 6b. reset at cnt=6, then a fresh window
      sig_sync = 1'b1; state = 1'b1;
      tick();
      repeat (6) tick();
      rst_n = 1'b0;
      #1;
      chk("midreset_db_out", db_out, INIT);
      chk("midreset_cf", count_finished, 1'b0);
      chk("midreset_rise", rise_pulse, 1'b0);
      chk("midreset_fall", fall_pulse, 1'b0);
      tick(); tick();
      rst_n = 1'b1; rise_seen = 0;
      tick();
      chk("release_no_pulse", rise_pulse, 1'b0);
      wait_cf(n);
      chk_int("after_reset_latency", n, DC);
      chk("after_reset_db_out", db_out, 1'b1);
      chk("after_reset_rise", rise_pulse, 1'b1);
      finish_handshake();
      $display("txn midreset: latency=%0d db_out=%b", n, db_out);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/debounce_part_2.md
Name: debounce_part_2

Overview:
Timing and output stage of the button/switch debouncer, and the responder to the arm stage (debounce_part_1).
- The arm stage raises a level ("state") when the synchronizer reports an input change.
- This block times a quiet window of DEBOUNCE_CYCLES clocks while that level is high.
- At window end it returns a one-cycle count_finished, which clears the arm stage.
- In the same cycle it commits the synchronized level to the debounced output and emits edge pulses.
- Sits between the synchronizer/arm stage and the user logic (FSMs, LED/7-seg drivers).

Parameters:
- DEBOUNCE_CYCLES, 500000, quiet-window length in clocks (10 ms at 50 MHz); legal range is ≥2.
- CNT_WIDTH, 19, counter width; must satisfy 2^CNT_WIDTH ≥ DEBOUNCE_CYCLES.
- INIT_LEVEL, 1'b0, reset value of db_out (1 for active-low buttons).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- state  input  1  arm level from debounce_part_1; high = window requested.
- sig_change  input  1  synchronizer change strobe; restarts the window while counting.
- sig_sync  input  1  synchronized raw input level.
- count_finished  output  1  one-cycle window-done pulse back to debounce_part_1.
- db_out  output  1  debounced level.
- rise_pulse  output  1  one-cycle pulse on db_out 0→1.
- fall_pulse  output  1  one-cycle pulse on db_out 1→0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM=IDLE, cnt=0.
  - count_finished=0, rise_pulse=0, fall_pulse=0.
  - db_out=INIT_LEVEL.
- All outputs are registered; no combinational path from any input to any output.
- FSM states IDLE, COUNT, DONE:
  - IDLE:
    - cnt held at 0.
    - If state=1 at an edge, go to COUNT with cnt=0.
  - COUNT:
    - Each edge, cnt+1.
    - If sig_change=1 at an edge, cnt←0 and stay in COUNT. Restart has priority over terminal count.
    - If state=0 at an edge (arm stage aborted), go to IDLE, cnt←0, no output update.
    - If cnt==DEBOUNCE_CYCLES-1 and sig_change=0 and state=1, go to DONE.
  - DONE:
    - Lasts exactly one cycle.
    - count_finished=1 throughout DONE.
    - Unconditional return to IDLE; the state input is ignored in DONE.
- Commit, on the edge entering DONE:
  - db_out←sig_sync, sampled at that edge.
  - If the new db_out differs from the old one, set rise_pulse or fall_pulse, matching the direction, for the DONE cycle only.
  - If equal, no pulse (a glitch rejected).
- Latency, with no restart: count_finished and db_out change DEBOUNCE_CYCLES clocks after the edge that entered COUNT.
- Handshake with the arm stage:
  - The arm stage clears state on the edge that ends DONE.
  - IDLE therefore sees state=0 on the following edge; no spurious re-arm.
- Re-arm: a sig_change arriving while in DONE or IDLE is handled by the arm stage. A new window starts from IDLE.
- Counter:
  - Unsigned, CNT_WIDTH bits.
  - Never exceeds DEBOUNCE_CYCLES-1, so no wrap.
  - Compare against DEBOUNCE_CYCLES-1 truncated to CNT_WIDTH.
- rise_pulse and fall_pulse are mutually exclusive.
- Reset asserted mid-window returns immediately to reset values. No pulse is produced on reset release.

Decomposition:
- Shared package debounce_pkg:
  - FSM state typedef (IDLE/COUNT/DONE, 2-bit encoding).
  - Default DEBOUNCE_CYCLES and CNT_WIDTH constants, shared with debounce_part_1 and the synchronizer.
- One sub-module, debounce_timer:
  - Inputs: clk, rst_n, clear, enable.
  - Outputs: cnt, terminal (cnt==DEBOUNCE_CYCLES-1).
- The FSM, commit logic and pulse logic stay in debounce_part_2.

Test Plan (DEBOUNCE_CYCLES=8, CNT_WIDTH=3, INIT_LEVEL=0):
1. Reset: hold rst_n=0 for 3 cycles with all inputs 1 → db_out=0, count_finished=0, no pulses; release → still 0 until state=1.
2. Clean press: sig_sync=1, state=1 (held until count_finished) → count_finished high 1 cycle exactly 8 clocks after COUNT entry; db_out=1 and rise_pulse=1 in that same cycle; rise_pulse=0 afterwards.
3. Bounce restart: during COUNT, pulse sig_change at cnt=5 and again at cnt=7 → count_finished occurs 8 clocks after the last sig_change; exactly one rise_pulse total.
4. Glitch rejection: db_out=1, sig_sync drops 2 cycles then returns to 1, state=1 → window completes, db_out stays 1, no fall_pulse, count_finished still pulses once.
5. Release: db_out=1, sig_sync=0, full window → db_out=0, fall_pulse=1 for one cycle, rise_pulse=0.
6. Abort and reset mid-window:
   - Drop state at cnt=4 → return to IDLE, no count_finished, db_out unchanged.
   - Separately, rst_n=0 at cnt=6 → immediate reset values; the next window counts from 0.
